serial_operand_serializer: RTL and testbench
============================================

// Module: serial_operand_serializer
//
// PURPOSE
//   Transmit side for the serial comparators: takes a pair of parallel words (A, B)
//   and shifts them out as two synchronous bitstreams a/b, one bit pair per beat.
//   Sits between a word source (valid/ready) and a serial comparator.
//   Frames each word with first/last flags so the consumer can reset its FSM per word.
//
// PARAMETERS
//   WIDTH  8  bits per word; legal range 2..64.
//
// PORTS
//   clk          in   1      rising-edge clock
//   rst          in   1      reset, asynchronous, active-low (0 = reset)
//   up_valid     in   1      word pair available on a_word/b_word
//   up_ready     out  1      serializer can accept a word pair this cycle
//   a_word       in   WIDTH  operand A
//   b_word       in   WIDTH  operand B
//   bit_valid    out  1      a/b/first/last are valid
//   bit_ready    in   1      consumer takes the current bit pair
//   a            out  1      serial bit of A
//   b            out  1      serial bit of B
//   first        out  1      current beat is bit 0 of the frame (the MSB by default)
//   last         out  1      current beat is the final bit of the frame
//
// BEHAVIOUR
//   - Reset (rst=0, async): state=ST_IDLE, count=0, shift regs=0.
//     All outputs 0 except up_ready, which is 1 once the FSM is in ST_IDLE.
//   - Handshakes:
//     - Word accepted when up_valid & up_ready.
//     - Bit pair transferred when bit_valid & bit_ready.
//   - FSM (2 states):
//     - ST_IDLE: bit_valid=0, up_ready=1. Accept -> load a_word/b_word into the
//       shift regs, count=0 -> ST_SHIFT.
//     - ST_SHIFT: bit_valid=1. Each transfer shifts both regs one place and count++.
//       On the transfer with count==WIDTH-1:
//       - if up_valid, load the next pair in the same cycle and stay in ST_SHIFT;
//       - otherwise go to ST_IDLE.
//   - up_ready = (state==ST_IDLE) | (state==ST_SHIFT & last & bit_ready).
//     up_ready combinationally depends on bit_ready. No combinational path from
//     up_valid to up_ready.
//   - Latency: the word accepted at edge N drives its first bit from cycle N+1
//     (registered outputs). Back-to-back frames have no bubble.
//   - Stall: while bit_valid & ~bit_ready, a, b, first, last and count hold.
//   - Flags: first = bit_valid & (count==0); last = bit_valid & (count==WIDTH-1).
//     WIDTH>=2, so first and last are never both 1.
//   - Bit order (default): a = a_reg[WIDTH-1], b = b_reg[WIDTH-1]; shift left,
//     fill with 0.
//   - Counter: $clog2(WIDTH) bits; wraps to 0 on frame reload.
//   - up_valid while in ST_SHIFT with count<WIDTH-1: up_ready=0, nothing is loaded,
//     the source must hold its data.
//   - Reset mid-frame: the frame is discarded and no partial bits follow reset release.
//   - a/b are 0 whenever bit_valid=0.
//
// CONFIGURATION
//   - SERIAL_SERIALIZER_LSB_FIRST_EN defined:
//     - a = a_reg[0], b = b_reg[0]; shift right, fill with 0;
//     - first marks the LSB beat;
//     - use this to drive the least-significant-first comparator.
//   - Undefined: MSB-first, as described above.
//   - Handshake, latency and flags are identical in both builds.
//
// STRUCTURE
//   - Package serial_ser_pkg:
//     - typedef enum logic {ST_IDLE, ST_SHIFT} ser_state_t;
//     - localparam int SER_MAX_WIDTH = 64.
//   - Sub-module serial_shift_reg #(WIDTH):
//     - ports: load, shift, d, q_bit;
//     - direction selected by the macro;
//     - instantiated twice (A and B).
//   - Top module holds the FSM, the counter and the flag logic.
//
// TESTING
//   1. Reset, then A=8'hA5, B=8'h5A, bit_ready=1:
//      - a = 1,0,1,0,0,1,0,1; b = 0,1,0,1,1,0,1,0;
//      - first on beat 0, last on beat 7; then idle with up_ready=1.
//   2. Back-to-back pairs (8'hFF,8'h00) then (8'h0F,8'h0F), up_valid held:
//      16 consecutive bit_valid beats, no bubble, up_ready pulses with the last beat.
//   3. bit_ready=0 for 3 cycles at beat 4 of A=8'h80:
//      - a/b/count frozen during the stall;
//      - the frame completes in 11 cycles total and the bit order is intact.
//   4. rst=0 asserted mid-frame at beat 3:
//      - outputs go to 0 immediately (async), up_ready=1 after release;
//      - the next word starts with first=1.
//   5. Serializer -> serial comparator, A=8'h3C, B=8'h3D, comparator reset on first:
//      at the last beat, a_less_b=1 (a_greater_b=1 for the swapped pair).
//   6. SERIAL_SERIALIZER_LSB_FIRST_EN build, A=8'h01:
//      a = 1,0,0,0,0,0,0,0; first on the 1 bit.

Source files
------------

// File: rtl/serial_ser_pkg.sv
// Shared types and limits for the operand serializer.
package serial_ser_pkg;

  // Two-state framing FSM: waiting for a word pair, or shifting one out.
  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } ser_state_t;

  // Widest word the serializer is meant to carry.
  localparam int SER_MAX_WIDTH = 64;

endpackage

// File: rtl/serial_shift_reg.sv
// Parallel-load shift register presenting one serial bit.
// Build option SERIAL_SERIALIZER_LSB_FIRST_EN: shift right and present
// bit 0 (LSB first); otherwise shift left and present the MSB.
module serial_shift_reg #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             shift,
  input  logic [WIDTH-1:0] d,
  output logic             q_bit
);

  logic [WIDTH-1:0] r_data;

  // Load has priority so a reload on the final transfer replaces the spent word.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_data <= '0;
    end else if (load) begin
      r_data <= d;
    end else if (shift) begin
`ifdef SERIAL_SERIALIZER_LSB_FIRST_EN
      r_data <= {1'b0, r_data[WIDTH-1:1]};
`else
      r_data <= {r_data[WIDTH-2:0], 1'b0};
`endif
    end
  end

`ifdef SERIAL_SERIALIZER_LSB_FIRST_EN
  assign q_bit = r_data[0];
`else
  assign q_bit = r_data[WIDTH-1];
`endif

endmodule

// File: rtl/serial_operand_serializer.sv
// Serializes a parallel (A, B) word pair into two framed bitstreams.
// Build option SERIAL_SERIALIZER_LSB_FIRST_EN selects LSB-first order;
// handshake, latency and first/last flags are the same either way.
module serial_operand_serializer
  import serial_ser_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             up_valid,
  output logic             up_ready,
  input  logic [WIDTH-1:0] a_word,
  input  logic [WIDTH-1:0] b_word,
  output logic             bit_valid,
  input  logic             bit_ready,
  output logic             a,
  output logic             b,
  output logic             first,
  output logic             last
);

  localparam int              CW       = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0]   LAST_CNT = CW'(WIDTH - 1);

  if (WIDTH < 2 || WIDTH > SER_MAX_WIDTH) begin : g_bad_width
    $error("serial_operand_serializer: WIDTH out of range");
  end

  ser_state_t      r_state;
  ser_state_t      w_state_next;
  logic [CW-1:0]   r_count;
  logic            w_at_last;
  logic            w_load;
  logic            w_shift;
  logic            w_a_bit;
  logic            w_b_bit;

  assign w_at_last = (r_count == LAST_CNT);
  assign w_load    = up_valid & up_ready;
  assign w_shift   = bit_valid & bit_ready;

  // State register; reset drops any frame in flight.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next state and handshake outputs; ready on the final beat allows gapless frames.
  always_comb begin
    w_state_next = r_state;
    up_ready     = 1'b0;
    bit_valid    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        up_ready = 1'b1;
        if (up_valid) begin
          w_state_next = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        bit_valid = 1'b1;
        up_ready  = w_at_last & bit_ready;
        if (w_at_last && bit_ready && !up_valid) begin
          w_state_next = ST_IDLE;
        end
      end
      default: begin
        w_state_next = ST_IDLE;
      end
    endcase
  end

  // Beat counter: restarts on every load and after the final transfer, holds on stall.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_count <= '0;
    end else if (w_load) begin
      r_count <= '0;
    end else if (w_shift) begin
      if (w_at_last) begin
        r_count <= '0;
      end else begin
        r_count <= r_count + CW'(1);
      end
    end
  end

  serial_shift_reg #(.WIDTH(WIDTH)) u_shift_a (
    .clk   (clk),
    .rst   (rst),
    .load  (w_load),
    .shift (w_shift),
    .d     (a_word),
    .q_bit (w_a_bit)
  );

  serial_shift_reg #(.WIDTH(WIDTH)) u_shift_b (
    .clk   (clk),
    .rst   (rst),
    .load  (w_load),
    .shift (w_shift),
    .d     (b_word),
    .q_bit (w_b_bit)
  );

  // Data and flags are forced low outside a frame.
  assign a     = bit_valid & w_a_bit;
  assign b     = bit_valid & w_b_bit;
  assign first = bit_valid & (r_count == '0);
  assign last  = bit_valid & w_at_last;

endmodule

// File: tb/tb_serial_operand_serializer.sv
// Bench for serial_operand_serializer: directed framing scenarios plus a
// randomized stream checked beat-by-beat against an expected bit queue.
// Honours SERIAL_SERIALIZER_LSB_FIRST_EN for the expected bit order.
module tb_serial_operand_serializer;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         up_valid = 1'b0;
  logic         up_ready;
  logic [W-1:0] a_word = '0;
  logic [W-1:0] b_word = '0;
  logic         bit_valid;
  logic         bit_ready = 1'b0;
  logic         a;
  logic         b;
  logic         first;
  logic         last;

  int checks = 0;
  int errors = 0;

  bit [1:0] exp_q[$];
  int       beat_idx = 0;
  bit       mon_en = 1'b0;
  bit       rand_br = 1'b0;

  serial_operand_serializer #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .up_valid  (up_valid),
    .up_ready  (up_ready),
    .a_word    (a_word),
    .b_word    (b_word),
    .bit_valid (bit_valid),
    .bit_ready (bit_ready),
    .a         (a),
    .b         (b),
    .first     (first),
    .last      (last)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Bit k of the frame for a given word, straight from the chosen bit order.
  function automatic bit model_bit(input logic [W-1:0] w, input int k);
`ifdef SERIAL_SERIALIZER_LSB_FIRST_EN
    return w[k];
`else
    return w[W-1-k];
`endif
  endfunction

  task automatic push_word(input logic [W-1:0] wa, input logic [W-1:0] wb);
    for (int k = 0; k < W; k++) begin
      exp_q.push_back({model_bit(wa, k), model_bit(wb, k)});
    end
  endtask

  // Monitor: every valid beat must match the queue head; flags follow beat position.
  always @(negedge clk) begin
    if (!rst) begin
      exp_q.delete();
      beat_idx = 0;
    end else if (mon_en) begin
      if (bit_valid) begin
        check_val("mon_q_nonempty", 64'(exp_q.size() != 0), 1);
        if (exp_q.size() != 0) begin
          check_val("mon_a", a, exp_q[0][1]);
          check_val("mon_b", b, exp_q[0][0]);
        end
        check_val("mon_first", first, 64'(beat_idx == 0));
        check_val("mon_last", last, 64'(beat_idx == W - 1));
        check_val("mon_up_ready", up_ready, 64'((beat_idx == W - 1) && bit_ready));
        if (bit_ready) begin
          if (exp_q.size() != 0) void'(exp_q.pop_front());
          beat_idx = (beat_idx + 1) % W;
        end
      end else begin
        check_val("idle_ab", {a, b, first, last}, 0);
        check_val("idle_up_ready", up_ready, 1);
      end
    end
  end

  // Random consumer back-pressure, changed just after each rising edge.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (rand_br) bit_ready = ($urandom_range(0, 3) != 0);
    end
  end

  // Present a word pair and hold it until accepted; returns just after the accepting edge.
  task automatic send(input logic [W-1:0] wa, input logic [W-1:0] wb);
    bit ok;
    a_word   = wa;
    b_word   = wb;
    up_valid = 1'b1;
    push_word(wa, wb);
    ok = 1'b0;
    for (int t = 0; t < 200 && !ok; t++) begin
      @(negedge clk);
      ok = up_ready;
      @(posedge clk);
      #1;
    end
    check_val("send_accept", ok, 1);
    $display("word a=%h b=%h accepted at %0t", wa, wb, $time);
  endtask

  task automatic expect_run(input int n, input string tag);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      check_val(tag, bit_valid, 1);
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_idle();
    bit done;
    done = 1'b0;
    for (int t = 0; t < 300 && !done; t++) begin
      @(negedge clk);
      done = !bit_valid;
      @(posedge clk);
      #1;
    end
    check_val("wait_idle", done, 1);
  endtask

  // Bench-side serial comparator, cleared on first, result read on last.
  task automatic compare_pair(input logic [W-1:0] wa, input logic [W-1:0] wb,
                              input bit exp_lt, input bit exp_gt);
    bit lt, gt, dec, done;
    lt = 0; gt = 0; dec = 0; done = 0;
    bit_ready = 1'b1;
    send(wa, wb);
    up_valid = 1'b0;
    for (int t = 0; t < 40 && !done; t++) begin
      @(negedge clk);
      if (bit_valid) begin
        if (first) begin lt = 0; gt = 0; dec = 0; end
`ifdef SERIAL_SERIALIZER_LSB_FIRST_EN
        if (a != b) begin lt = b; gt = a; end
`else
        if (!dec && a != b) begin dec = 1; lt = b; gt = a; end
`endif
        if (last) done = 1;
      end
      @(posedge clk);
      #1;
    end
    check_val("cmp_done", done, 1);
    check_val("cmp_lt", lt, exp_lt);
    check_val("cmp_gt", gt, exp_gt);
    wait_idle();
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

  initial begin
    logic [W-1:0] acc_a, acc_b;
    int           cnt;
    bit           drained;

    // Reset state
    rst = 1'b0;
    bit_ready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_val("rst_outputs", {bit_valid, a, b, first, last}, 0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    mon_en = 1'b1;
    @(negedge clk);
    check_val("rst_up_ready", up_ready, 1);
    check_val("rst_bit_valid", bit_valid, 0);
    @(posedge clk);
    #1;

    // Single frame A5/5A, no stalls, first bit right after the accept edge
    send(8'hA5, 8'h5A);
    up_valid = 1'b0;
    acc_a = '0;
    acc_b = '0;
    for (int i = 0; i < W; i++) begin
      @(negedge clk);
      check_val("t1_valid", bit_valid, 1);
      acc_a = {acc_a[W-2:0], a};
      acc_b = {acc_b[W-2:0], b};
      @(posedge clk);
      #1;
    end
    check_val("t1_a_seq", acc_a, 8'hA5);
    check_val("t1_b_seq", acc_b, 8'h5A);
    @(negedge clk);
    check_val("t1_idle_valid", bit_valid, 0);
    check_val("t1_idle_ready", up_ready, 1);
    @(posedge clk);
    #1;

    // Back-to-back frames with up_valid held: 16 gapless beats
    send(8'hFF, 8'h00);
    fork
      begin
        send(8'h0F, 8'h0F);
        up_valid = 1'b0;
      end
      expect_run(2 * W, "t2_gapless");
    join
    @(negedge clk);
    check_val("t2_idle_valid", bit_valid, 0);
    @(posedge clk);
    #1;

    // Three-cycle stall at beat 4: frame spans 11 cycles
    send(8'h80, 8'h01);
    up_valid = 1'b0;
    cnt = 0;
    for (int k = 0; k < 30; k++) begin
      bit_ready = !(k >= 4 && k <= 6);
      @(negedge clk);
      if (!bit_valid) break;
      cnt++;
      @(posedge clk);
      #1;
    end
    @(posedge clk);
    #1;
    bit_ready = 1'b1;
    check_val("t3_frame_cycles", cnt, 11);

    // Asynchronous reset at beat 3
    mon_en = 1'b0;
    send(8'hA5, 8'h5A);
    up_valid = 1'b0;
    repeat (3) begin
      @(negedge clk);
      @(posedge clk);
      #1;
    end
    @(negedge clk);
    check_val("t4_pre_valid", bit_valid, 1);
    #2;
    rst = 1'b0;
    #1;
    check_val("t4_async_clear", {bit_valid, a, b, first, last}, 0);
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(negedge clk);
    check_val("t4_rel_valid", bit_valid, 0);
    check_val("t4_rel_ready", up_ready, 1);
    @(posedge clk);
    #1;
    mon_en = 1'b1;
    send(8'hC3, 8'h3C);
    up_valid = 1'b0;
    @(negedge clk);
    check_val("t4_next_first", {bit_valid, first}, 2'b11);
    @(posedge clk);
    #1;
    wait_idle();

    // Feeding a serial comparator
    compare_pair(8'h3C, 8'h3D, 1'b1, 1'b0);
    compare_pair(8'h3D, 8'h3C, 1'b0, 1'b1);

    // Bit order with A=01: only the LSB-first build opens with a 1
    send(8'h01, 8'h00);
    up_valid = 1'b0;
    @(negedge clk);
`ifdef SERIAL_SERIALIZER_LSB_FIRST_EN
    check_val("t6_first_a", {first, a}, 2'b11);
`else
    check_val("t6_first_a", {first, a}, 2'b10);
`endif
    @(posedge clk);
    #1;
    wait_idle();

    // Randomized words, gaps and back-pressure
    rand_br = 1'b1;
    for (int n = 0; n < 40; n++) begin
      send(W'($urandom), W'($urandom));
      if ($urandom_range(0, 1) == 1) begin
        up_valid = 1'b0;
        repeat ($urandom_range(0, 3)) begin
          @(posedge clk);
          #1;
        end
      end
    end
    up_valid = 1'b0;
    drained = 1'b0;
    for (int t = 0; t < 3000 && !drained; t++) begin
      @(negedge clk);
      drained = (exp_q.size() == 0) && !bit_valid;
      @(posedge clk);
      #1;
    end
    rand_br = 1'b0;
    bit_ready = 1'b1;
    check_val("rand_drained", drained, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
